button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Sits directly upstream of the player modules.
- Takes the 9 raw, bouncing, asynchronous board push-buttons and synchronises them to clk.
- Debounces each button independently.
- Emits clean level signals plus single-cycle press and release pulses, so a player scores one hit per physical press.
- Also emits a lowest-index encoded press event for consumers that handle one hit per cycle.

Parameters:
- NUM_BUTTONS, 9: number of button channels.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range is 1 or more.
- ACTIVE_LOW, 1: 1 means a raw input of 0 means pressed; 0 means a raw input of 1 means pressed.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- buttons_raw  input  NUM_BUTTONS  raw board buttons; asynchronous to clk.
- buttons_level  output  NUM_BUTTONS  debounced state; 1 means pressed.
- buttons_press  output  NUM_BUTTONS  one-cycle pulse on each accepted 0-to-1 transition of buttons_level.
- buttons_release  output  NUM_BUTTONS  one-cycle pulse on each accepted 1-to-0 transition of buttons_level.
- any_press  output  1  OR of buttons_press.
- press_idx  output  4  index of the lowest set bit of buttons_press; 0 when any_press is 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both synchroniser flops load the inactive raw level.
  - All counters clear to 0.
  - buttons_level, buttons_press, buttons_release, any_press and press_idx all go to 0.
- Polarity: the raw input is normalised to pressed = 1 (inverted when ACTIVE_LOW = 1) before the synchroniser.
- Synchroniser: two flops per channel, sync1 then sync2. No logic sits between them.
- Counter width is CNT_W = max(1, clog2(DEBOUNCE_CYCLES)). Each channel compares sync2 with its stable register:
  - sync2 equals stable: the counter clears to 0.
  - sync2 differs from stable and counter < DEBOUNCE_CYCLES-1: the counter increments.
  - sync2 differs from stable and counter = DEBOUNCE_CYCLES-1: stable loads sync2 and the counter clears. In the same edge the press flop (if the new value is 1) or the release flop (if the new value is 0) loads 1. Otherwise those flops load 0.
- Latency: a raw change held steady, first sampled at edge 1, is reflected on buttons_level after edge 2+DEBOUNCE_CYCLES. The press or release pulse is high for exactly the first cycle of the new level.
- Glitch handling: any mismatch run shorter than DEBOUNCE_CYCLES clears the counter and produces no output change. A bounce restarts the count from 0.
- Each channel produces at most one pulse per accepted transition. Press and release can never both be high on the same channel.
- Channels are fully independent. Simultaneous acceptances produce pulses in the same cycle.
- any_press and press_idx are combinational from the registered buttons_press. press_idx is a priority encode with the lowest index winning.
- Reset mid-count: the in-progress count is discarded. After rst_n deasserts, a still-held button requires the full 2+DEBOUNCE_CYCLES latency again and then produces a press pulse.
- Held button: buttons_level stays 1 and no repeated press pulses occur.

Decomposition:
- Shared package whack_pkg holds:
  - NUM_BUTTONS_DEF = 9.
  - SYNC_STAGES = 2.
  - The clog2-based counter width function.
- Natural sub-module: debounce_channel. It is one button's synchroniser, counter, stable register and press/release flops, instantiated NUM_BUTTONS times by a generate loop.
- The top level adds only the polarity normalisation, any_press and the press_idx encoder.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and ACTIVE_LOW=1.
1. Reset: rst_n low for 3 cycles, raw all 1s, then deasserted. All outputs are 0 and stay 0 for 20 cycles.
2. Clean press: buttons_raw[3] driven 0 just before edge 1 and held. buttons_level[3] rises after edge 6. buttons_press[3] is high for exactly one cycle. any_press=1 and press_idx=3 in that cycle.
3. Bounce: buttons_raw[0] toggled every 2 cycles for 20 cycles, then held 0. No pulse during bouncing. Exactly one press[0] pulse, 6 edges after the final transition.
4. Simultaneous press: raw bits 2 and 7 driven 0 on the same edge. press[2] and press[7] are high in the same cycle, any_press=1, press_idx=2.
5. Release: held button 3 returned to 1. buttons_level[3] falls after 6 edges, with a single release[3] pulse and no press pulse.
6. Reset mid-count: rst_n pulsed low when button 5's counter=2, with the raw press held throughout. Outputs are 0 during reset. level[5] rises 6 edges after rst_n deasserts, with exactly one press[5] pulse.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared constants and helpers for the push-button front end.
package whack_pkg;

  localparam int NUM_BUTTONS_DEF = 9;
  localparam int SYNC_STAGES     = 2;

  // Debounce counter width; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button: two-flop synchroniser, stability counter, accepted level and edge pulses.
module debounce_channel
  import whack_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [CNT_W-1:0]       cnt;
  logic                   stable;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign level    = stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  // Any disagreement shorter than DEBOUNCE_CYCLES restarts the count from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      stable        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else if (sync_out == stable) begin
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else if (cnt == CNT_MAX) begin
      cnt           <= '0;
      stable        <= sync_out;
      press_pulse   <= sync_out;
      release_pulse <= ~sync_out;
    end else begin
      cnt           <= cnt + 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Board push-button front end: polarity fix, per-button debounce, press summary and encoder.
module button_conditioner
  import whack_pkg::*;
#(
  parameter int NUM_BUTTONS     = NUM_BUTTONS_DEF,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons_level,
  output logic [NUM_BUTTONS-1:0] buttons_press,
  output logic [NUM_BUTTONS-1:0] buttons_release,
  output logic                   any_press,
  output logic [3:0]             press_idx
);

  logic [NUM_BUTTONS-1:0] raw_norm;

  assign raw_norm = ACTIVE_LOW ? ~buttons_raw : buttons_raw;

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw          (raw_norm[g]),
      .level        (buttons_level[g]),
      .press_pulse  (buttons_press[g]),
      .release_pulse(buttons_release[g])
    );
  end

  assign any_press = |buttons_press;

  // Scan from the top so the lowest pressed index is written last and wins.
  always_comb begin
    press_idx = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (buttons_press[i]) press_idx = 4'(i);
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a 4-cycle debounce and active-low buttons.
module tb_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic [8:0] buttons_raw;
  logic [8:0] buttons_level;
  logic [8:0] buttons_press;
  logic [8:0] buttons_release;
  logic       any_press;
  logic [3:0] press_idx;

  int total = 0;
  int bad   = 0;

  button_conditioner #(
    .NUM_BUTTONS    (9),
    .DEBOUNCE_CYCLES(4),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .buttons_raw    (buttons_raw),
    .buttons_level  (buttons_level),
    .buttons_press  (buttons_press),
    .buttons_release(buttons_release),
    .any_press      (any_press),
    .press_idx      (press_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n       = 1'b0;
    buttons_raw = 9'h1FF;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({buttons_level, buttons_press, buttons_release, any_press, press_idx} !== '0) begin
        bad++;
        $display("FAIL reset_hold: level=%h press=%h rel=%h any=%b idx=%0d required all 0",
                 buttons_level, buttons_press, buttons_release, any_press, press_idx);
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      total++;
      if ({buttons_level, buttons_press, buttons_release, any_press, press_idx} !== '0) begin
        bad++;
        $display("FAIL reset_idle c=%0d: level=%h press=%h rel=%h any=%b idx=%0d required all 0",
                 c, buttons_level, buttons_press, buttons_release, any_press, press_idx);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [8:0] exp_level, exp_press;
    buttons_raw[3] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_level = (e >= 6) ? 9'h008 : 9'h000;
      exp_press = (e == 6) ? 9'h008 : 9'h000;
      total++;
      if (buttons_level !== exp_level || buttons_press !== exp_press || buttons_release !== 9'h0) begin
        bad++;
        $display("FAIL clean_press e=%0d: level=%h press=%h rel=%h required level=%h press=%h rel=0",
                 e, buttons_level, buttons_press, buttons_release, exp_level, exp_press);
      end
      total++;
      if (any_press !== (e == 6) || press_idx !== ((e == 6) ? 4'd3 : 4'd0)) begin
        bad++;
        $display("FAIL clean_press_enc e=%0d: any=%b idx=%0d required any=%b idx=%0d",
                 e, any_press, press_idx, (e == 6), (e == 6) ? 3 : 0);
      end
    end
  endtask

  task automatic test_bounce();
    logic [8:0] exp_level, exp_press;
    for (int k = 0; k < 10; k++) begin
      buttons_raw[0] = k[0];
      repeat (2) begin
        @(negedge clk);
        total++;
        if (buttons_level !== 9'h008 || buttons_press !== 9'h0 || buttons_release !== 9'h0) begin
          bad++;
          $display("FAIL bounce_quiet k=%0d: level=%h press=%h rel=%h required level=008 press=0 rel=0",
                   k, buttons_level, buttons_press, buttons_release);
        end
      end
    end
    buttons_raw[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_level = (e >= 6) ? 9'h009 : 9'h008;
      exp_press = (e == 6) ? 9'h001 : 9'h000;
      total++;
      if (buttons_level !== exp_level || buttons_press !== exp_press ||
          any_press !== (e == 6) || press_idx !== 4'd0) begin
        bad++;
        $display("FAIL bounce_settle e=%0d: level=%h press=%h any=%b idx=%0d required level=%h press=%h any=%b idx=0",
                 e, buttons_level, buttons_press, any_press, press_idx, exp_level, exp_press, (e == 6));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [8:0] exp_level, exp_press;
    buttons_raw[2] = 1'b0;
    buttons_raw[7] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_level = (e >= 6) ? 9'h08D : 9'h009;
      exp_press = (e == 6) ? 9'h084 : 9'h000;
      total++;
      if (buttons_level !== exp_level || buttons_press !== exp_press) begin
        bad++;
        $display("FAIL simul e=%0d: level=%h press=%h required level=%h press=%h",
                 e, buttons_level, buttons_press, exp_level, exp_press);
      end
      total++;
      if (any_press !== (e == 6) || press_idx !== ((e == 6) ? 4'd2 : 4'd0)) begin
        bad++;
        $display("FAIL simul_enc e=%0d: any=%b idx=%0d required any=%b idx=%0d",
                 e, any_press, press_idx, (e == 6), (e == 6) ? 2 : 0);
      end
    end
  endtask

  task automatic test_release();
    logic [8:0] exp_level, exp_rel;
    buttons_raw[3] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      exp_level = (e >= 6) ? 9'h085 : 9'h08D;
      exp_rel   = (e == 6) ? 9'h008 : 9'h000;
      total++;
      if (buttons_level !== exp_level || buttons_release !== exp_rel ||
          buttons_press !== 9'h0 || any_press !== 1'b0) begin
        bad++;
        $display("FAIL release e=%0d: level=%h rel=%h press=%h any=%b required level=%h rel=%h press=0 any=0",
                 e, buttons_level, buttons_release, buttons_press, any_press, exp_level, exp_rel);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [8:0] exp_level, exp_press;
    buttons_raw = 9'h1FF;
    repeat (8) @(negedge clk);
    total++;
    if (buttons_level !== 9'h0) begin
      bad++;
      $display("FAIL release_all: level=%h required 000", buttons_level);
    end
    buttons_raw[5] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({buttons_level, buttons_press, buttons_release, any_press, press_idx} !== '0) begin
      bad++;
      $display("FAIL mid_reset_async: level=%h press=%h rel=%h any=%b idx=%0d required all 0",
               buttons_level, buttons_press, buttons_release, any_press, press_idx);
    end
    repeat (2) begin
      @(negedge clk);
      total++;
      if ({buttons_level, buttons_press, buttons_release, any_press, press_idx} !== '0) begin
        bad++;
        $display("FAIL mid_reset_hold: level=%h press=%h rel=%h any=%b idx=%0d required all 0",
                 buttons_level, buttons_press, buttons_release, any_press, press_idx);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      exp_level = (e >= 6) ? 9'h020 : 9'h000;
      exp_press = (e == 6) ? 9'h020 : 9'h000;
      total++;
      if (buttons_level !== exp_level || buttons_press !== exp_press ||
          press_idx !== ((e == 6) ? 4'd5 : 4'd0)) begin
        bad++;
        $display("FAIL mid_reset_after e=%0d: level=%h press=%h idx=%0d required level=%h press=%h idx=%0d",
                 e, buttons_level, buttons_press, press_idx, exp_level, exp_press, (e == 6) ? 5 : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_release();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
